led_seq_addr_gen: RTL and testbench
===================================

Name: led_seq_addr_gen

Overview:
- Upstream sequencer for the LED pattern ROM stage, a 4-bit-wide block RAM read through a 12-bit address, an enable and a 4-bit data output.
- Divides the fabric clock down to a visible step rate and walks the ROM address space.
- Drives the ROM enable and address, then captures the returned pattern into a registered LED output.
- Sits between the clock/control logic and the reconfigurable pattern ROM.

Parameters:
PRESCALE, 50000000, clk cycles per pattern step; legal range is 4 to 2^28-1.
ADDR_MAX, 12'hFFF, last ROM address before wrap to 0.
ADDR_STEP, 1, address increment per step; must be nonzero and at most ADDR_MAX.

Ports:
clk  in  1  single system clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
run  in  1  level; 1 means free-running stepping, 0 means paused.
step_req  in  1  one-cycle pulse requesting a single step while paused.
rom_en  out  1  ROM read enable (ENA/REGCEA of the pattern ROM).
rom_addr  out  12  ROM word address.
rom_data  in  4  ROM read data, valid 1 cycle after an enabled edge.
led  out  4  registered LED pattern.
led_update  out  1  one-cycle pulse in the first cycle a new led value is visible.
busy  out  1  high when the FSM is outside IDLE.

Behaviour:
- Reset (async assert, sync release): prescaler=0, state=IDLE, rom_addr=0, rom_en=0, led=4'h0, led_update=0, busy=0. Reset asserted in any state aborts the step immediately; no partial led write occurs.
- Prescaler (28-bit):
  - Counts only when run=1 and state=IDLE.
  - Holds its value (is not cleared) while run=0 or while busy.
  - At count PRESCALE-1 the next edge sets count=0 and moves the state IDLE->FETCH.
- FSM states are IDLE, FETCH and CAPTURE:
  - IDLE: rom_en=0. Goes to FETCH on prescaler wrap. Also goes to FETCH on step_req=1 when run=0. step_req while run=1 is ignored.
  - FETCH: rom_en=1 with rom_addr stable. Always goes to CAPTURE on the next edge.
  - CAPTURE: rom_en=1 (so the ROM's sync set/reset does not clear its output) and rom_data is valid.
  - At the CAPTURE->IDLE edge: led<=rom_data, led_update<=1 for the following cycle, and rom_addr advances.
- Step cadence:
  - Latency from tick edge to led visible is 2 cycles.
  - Steady-state step period is PRESCALE+2 cycles; the 2 busy cycles do not advance the prescaler.
- Address advance: next = rom_addr+ADDR_STEP. If that exceeds ADDR_MAX, next = rom_addr+ADDR_STEP-(ADDR_MAX+1). Use 13-bit arithmetic, no overflow.
- Boundary conditions:
  - A run fall during FETCH or CAPTURE still completes the step.
  - step_req during FETCH or CAPTURE is dropped, not queued.
  - A run and step_req change in the same cycle is evaluated on registered state: IDLE with run=1 takes no step on the request.
- rom_addr changes only at the CAPTURE->IDLE edge, never while rom_en=1.

Optional Feature:
- Macro: LED_SEQ_REVERSE_EN.
- Defined:
  - Adds input port dir (1 bit), sampled at the CAPTURE->IDLE edge.
  - dir=0 increments as above.
  - dir=1 computes next = rom_addr-ADDR_STEP; on underflow next = rom_addr-ADDR_STEP+(ADDR_MAX+1).
- Undefined: no dir port; increment only.

Test Plan:
1. Reset check: rst pulse mid-cycle -> all outputs 0 asynchronously. After release with run=0, no rom_en activity for 100 cycles.
2. Free run (PRESCALE=4, ADDR_MAX=3, ROM model 1,2,4,8): run=1 from cycle 0 after reset.
   - rom_en high in cycles 4-5.
   - led=1 with led_update pulse in cycle 6.
   - Subsequent leds 2,4,8,1 every 6 cycles, with rom_addr wrapping 3->0.
3. Pause/resume: with PRESCALE=4, drop run at prescaler=2 for 10 cycles. Prescaler holds 2, then the tick arrives 2 cycles after run returns high.
4. Single step: run=0 and step_req pulse in IDLE -> FETCH next cycle, led updated 2 cycles later, rom_addr+1. A second step_req during CAPTURE is dropped.
5. Reset mid-operation: assert rst during CAPTURE -> led stays at its prior value... then forced to 0 by the reset; rom_addr=0; no led_update pulse.
6. Reverse (LED_SEQ_REVERSE_EN, ADDR_STEP=1, ADDR_MAX=3): dir=1 from address 0 -> addresses 3,2,1,0,3. With ADDR_STEP=3, ADDR_MAX=4, forward run from 0 -> 3,1,4,2.

Source files
------------

// File: rtl/led_seq_addr_gen.sv
// LED pattern sequencer: prescaled step tick, ROM fetch/capture FSM, wrapping address walk.
// Define LED_SEQ_REVERSE_EN to add the dir input for decrementing address walks.
module led_seq_addr_gen #(
    parameter int          PRESCALE  = 50000000,
    parameter logic [11:0] ADDR_MAX  = 12'hFFF,
    parameter int          ADDR_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        step_req,
`ifdef LED_SEQ_REVERSE_EN
    input  logic        dir,
`endif
    output logic        rom_en,
    output logic [11:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [3:0]  led,
    output logic        led_update,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [27:0] PRESC_LAST = 28'(PRESCALE - 1);
    localparam logic [12:0] STEP13     = 13'(ADDR_STEP);
    localparam logic [12:0] WRAP13     = {1'b0, ADDR_MAX} + 13'd1;

    state_t      r_state;
    logic [27:0] r_presc;
    logic        w_dir;
    logic [11:0] w_addr_next;

`ifdef LED_SEQ_REVERSE_EN
    assign w_dir = dir;
`else
    assign w_dir = 1'b0;
`endif

    // 13-bit so the forward sum cannot overflow before the wrap compare
    function automatic logic [11:0] next_addr(input logic [11:0] a, input logic down);
        logic [12:0] s;
        if (!down) begin
            s = {1'b0, a} + STEP13;
            if (s > {1'b0, ADDR_MAX})
                s = s - WRAP13;
        end else begin
            if ({1'b0, a} >= STEP13)
                s = {1'b0, a} - STEP13;
            else
                s = {1'b0, a} + WRAP13 - STEP13;
        end
        return s[11:0];
    endfunction

    assign w_addr_next = next_addr(rom_addr, w_dir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_presc    <= 28'd0;
            rom_en     <= 1'b0;
            rom_addr   <= 12'd0;
            led        <= 4'h0;
            led_update <= 1'b0;
            busy       <= 1'b0;
        end else begin
            led_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Prescaler only advances while idle, so busy cycles stretch the period
                    if (run) begin
                        if (r_presc == PRESC_LAST) begin
                            r_presc <= 28'd0;
                            r_state <= S_FETCH;
                            rom_en  <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            r_presc <= r_presc + 28'd1;
                        end
                    end else if (step_req) begin
                        r_state <= S_FETCH;
                        rom_en  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // rom_en stays high here so the ROM's output reset cannot clear rom_data
                    r_state    <= S_IDLE;
                    rom_en     <= 1'b0;
                    busy       <= 1'b0;
                    led        <= rom_data;
                    led_update <= 1'b1;
                    rom_addr   <= w_addr_next;
                end
                default: begin
                    r_state <= S_IDLE;
                    rom_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_seq_addr_gen.sv
// Randomized bench for led_seq_addr_gen against a cycle-count reference model.
// A second instance free-runs with a non-unit step to exercise stepped wrap-around.
module tb_led_seq_addr_gen;

    localparam int PRESCALE = 4;
    localparam int AMAX     = 3;
    localparam int STEP     = 1;

    localparam int PRESCALE2 = 5;
    localparam int AMAX2     = 4;
    localparam int STEP2     = 3;

    logic        clk = 1'b0;
    logic        rst, run, step_req, dir;
    logic        rom_en, led_update, busy;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data = 4'h0;
    logic [3:0]  led;

    logic        rst2;
    logic        rom_en2, led_update2, busy2;
    logic [11:0] rom_addr2;
    logic [3:0]  rom_data2 = 4'h0;
    logic [3:0]  led2;

    logic [3:0]  rom_mem [0:3] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0]  rom2    [0:4];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: idle prescaler count, busy cycles remaining, address, led
    int          m_cnt, m_busy, m_addr;
    logic [3:0]  m_led;
    logic        m_upd;

    int a2_prev = 0;
    int n_upd2  = 0;
    int c2      = 0;

    always #5 clk = ~clk;

    led_seq_addr_gen #(.PRESCALE(PRESCALE), .ADDR_MAX(12'(AMAX)), .ADDR_STEP(STEP)) u_dut (
        .clk(clk), .rst(rst), .run(run), .step_req(step_req),
`ifdef LED_SEQ_REVERSE_EN
        .dir(dir),
`endif
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .led(led), .led_update(led_update), .busy(busy)
    );

    led_seq_addr_gen #(.PRESCALE(PRESCALE2), .ADDR_MAX(12'(AMAX2)), .ADDR_STEP(STEP2)) u_dut2 (
        .clk(clk), .rst(rst2), .run(1'b1), .step_req(1'b0),
`ifdef LED_SEQ_REVERSE_EN
        .dir(1'b0),
`endif
        .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .led(led2), .led_update(led_update2), .busy(busy2)
    );

    // Synchronous-read ROMs: data valid one cycle after an enabled edge
    always @(posedge clk) begin
        if (rom_en)
            rom_data <= (rom_addr <= 12'(AMAX)) ? rom_mem[int'(rom_addr)] : 4'h0;
        if (rom_en2)
            rom_data2 <= (rom_addr2 <= 12'(AMAX2)) ? rom2[int'(rom_addr2)] : 4'h0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_busy = 0;
        m_addr = 0;
        m_led  = 4'h0;
        m_upd  = 1'b0;
    endtask

    task automatic model_edge();
        logic down;
`ifdef LED_SEQ_REVERSE_EN
        down = dir;
`else
        down = 1'b0;
`endif
        m_upd = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_busy == 2) begin
            m_busy = 1;
        end else if (m_busy == 1) begin
            m_busy = 0;
            m_led  = rom_mem[m_addr];
            m_upd  = 1'b1;
            if (down)
                m_addr = (m_addr - STEP + AMAX + 1) % (AMAX + 1);
            else
                m_addr = (m_addr + STEP) % (AMAX + 1);
        end else if (run) begin
            if (m_cnt == PRESCALE - 1) begin
                m_cnt  = 0;
                m_busy = 2;
            end else begin
                m_cnt++;
            end
        end else if (step_req) begin
            m_busy = 2;
        end
    endtask

    task automatic check_all(input string ph);
        check_val({ph, "_rom_en"},     32'(rom_en),     32'(m_busy != 0));
        check_val({ph, "_busy"},       32'(busy),       32'(m_busy != 0));
        check_val({ph, "_rom_addr"},   32'(rom_addr),   32'(m_addr));
        check_val({ph, "_led"},        32'(led),        32'(m_led));
        check_val({ph, "_led_update"}, 32'(led_update), 32'(m_upd));
    endtask

    task automatic check_dut2();
        if (led_update2) begin
            check_val("d2_led", 32'(led2), 32'(rom2[a2_prev]));
            a2_prev = (a2_prev + STEP2) % (AMAX2 + 1);
            check_val("d2_addr", 32'(rom_addr2), 32'(a2_prev));
            n_upd2++;
        end
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge
    task automatic do_cycle(input string ph);
        @(posedge clk);
        model_edge();
        if (!rst2) c2++;
        @(negedge clk);
        check_all(ph);
        check_dut2();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        do_cycle("in_rst");
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i <= AMAX2; i++)
            rom2[i] = 4'($urandom_range(15, 0));
        rst      = 1'b1;
        rst2     = 1'b1;
        run      = 1'b0;
        step_req = 1'b0;
        dir      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");

        // Free run straight out of reset
        rst  = 1'b0;
        rst2 = 1'b0;
        run  = 1'b1;
        for (int i = 0; i < 100; i++)
            do_cycle("free");

        // Paused with no requests: ROM must stay idle
        run = 1'b0;
        for (int i = 0; i < 100; i++)
            do_cycle("pause");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29, 0) == 0)
                run = ~run;
            step_req = ($urandom_range(4, 0) == 0);
`ifdef LED_SEQ_REVERSE_EN
            if ($urandom_range(19, 0) == 0)
                dir = ~dir;
`endif
            if ((m_busy == 1 && $urandom_range(7, 0) == 0) || $urandom_range(299, 0) == 0)
                async_reset();
            else
                do_cycle("rand");
        end
        step_req = 1'b0;

        check_val("d2_progress", 32'(n_upd2), 32'(c2 / (PRESCALE2 + 2)));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
